// File: rtl/uart_mem_dump_pkg.sv
// Shared ASCII constants and state encodings for the UART bit-memory dump reader.
// Parity states exist only when UART_MEM_DUMP_PARITY_EN is defined.
package uart_mem_dump_pkg;

    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_1     = 8'h31;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_P     = 8'h50;

    typedef enum logic [2:0] {
        C_IDLE,
        C_ADDR_H,
        C_ADDR_L,
        C_LEN_H,
        C_LEN_L
    } cmd_state_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_EOL,
        S_END,
`ifdef UART_MEM_DUMP_PARITY_EN
        S_PAR_P,
        S_PAR_B,
        S_PAR_NL,
`endif
        S_DONE
    } dump_state_t;

endpackage

// File: rtl/uart_mem_dump_cmd.sv
// Parser for the 5-byte dump command 'D', ADDR_HI, ADDR_LO, LEN_HI, LEN_LO.
// Bytes arriving while the dump engine is busy are dropped silently.
module uart_mem_dump_cmd
    import uart_mem_dump_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              hold,
    output logic              start,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       len,
    output logic              err
);

    cmd_state_t  st, st_nxt;
    logic [7:0]  addr_hi;
    logic [7:0]  len_hi;
    logic [15:0] addr_full;
    logic        take;

    // start is included so a byte in the hand-off cycle cannot begin a new command
    assign take      = rx_valid && !hold && !start;
    assign addr_full = {addr_hi, rx_data};

    always_comb begin
        st_nxt = st;
        case (st)
            C_IDLE:   if (take && rx_data == CMD_DUMP) st_nxt = C_ADDR_H;
            C_ADDR_H: if (take) st_nxt = C_ADDR_L;
            C_ADDR_L: if (take) st_nxt = C_LEN_H;
            C_LEN_H:  if (take) st_nxt = C_LEN_L;
            C_LEN_L:  if (take) st_nxt = C_IDLE;
            default:  st_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st      <= C_IDLE;
            addr_hi <= '0;
            len_hi  <= '0;
            addr    <= '0;
            len     <= '0;
            start   <= 1'b0;
            err     <= 1'b0;
        end else begin
            st    <= st_nxt;
            start <= 1'b0;
            err   <= 1'b0;
            if (take) begin
                case (st)
                    C_IDLE:   err     <= (rx_data != CMD_DUMP);
                    C_ADDR_H: addr_hi <= rx_data;
                    C_ADDR_L: addr    <= addr_full[ADDR_W-1:0];
                    C_LEN_H:  len_hi  <= rx_data;
                    C_LEN_L: begin
                        len   <= {len_hi, rx_data};
                        start <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_mem_dump.sv
// Reads bits from a 1-bit memory and streams them to uart_tx as ASCII '0'/'1' lines.
// Optional trailing parity line "P<b>\n" when UART_MEM_DUMP_PARITY_EN is defined.
module uart_mem_dump
    import uart_mem_dump_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned LINE_BITS = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_we,
    input  logic              tx_wait,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned LC_W = $clog2(LINE_BITS + 1);

    dump_state_t       state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       rem_q;
    logic [15:0]       rem_dec;
    logic [LC_W-1:0]   line_q;
    logic [LC_W-1:0]   line_inc;
    logic              bit_q;
    logic              just_acc;
    logic              tx_req;
    logic [7:0]        tx_byte;
    logic              acc;
    logic              cmd_start;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       cmd_len;
`ifdef UART_MEM_DUMP_PARITY_EN
    logic              parity_q;
`endif

    uart_mem_dump_cmd #(.ADDR_W(ADDR_W)) u_cmd (
        .clk      (clk),
        .resetn   (resetn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .hold     (busy),
        .start    (cmd_start),
        .addr     (cmd_addr),
        .len      (cmd_len),
        .err      (err)
    );

    assign rem_dec     = rem_q - 16'd1;
    assign line_inc    = line_q + LC_W'(1);
    assign mem_rd_en   = (state == S_READ);
    assign mem_rd_addr = addr_q;
    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign done        = (state == S_DONE);
    // just_acc forces a one-cycle gap so tx_we always drops after each accepted byte
    assign tx_we       = tx_req && !just_acc;
    assign tx_data     = tx_byte;
    assign acc         = tx_we && !tx_wait;

    always_comb begin
        tx_req    = 1'b0;
        tx_byte   = '0;
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_start) state_nxt = (cmd_len == '0) ? S_END : S_READ;
            end
            S_READ: state_nxt = S_WAIT;
            S_WAIT: state_nxt = S_SEND;
            S_SEND: begin
                tx_req  = 1'b1;
                tx_byte = bit_q ? CH_1 : CH_0;
                if (acc) begin
                    if (line_inc == LC_W'(LINE_BITS)) state_nxt = S_EOL;
                    else if (rem_dec != '0)           state_nxt = S_READ;
                    else                              state_nxt = S_END;
                end
            end
            S_EOL: begin
                tx_req  = 1'b1;
                tx_byte = CH_NL;
                // END sees a cleared line count, so it adds no second '\n'
                if (acc) state_nxt = (rem_q != '0) ? S_READ : S_END;
            end
            S_END: begin
                tx_req  = (line_q != '0);
                tx_byte = CH_NL;
                if (line_q == '0 || acc) begin
`ifdef UART_MEM_DUMP_PARITY_EN
                    state_nxt = S_PAR_P;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef UART_MEM_DUMP_PARITY_EN
            S_PAR_P: begin
                tx_req  = 1'b1;
                tx_byte = CH_P;
                if (acc) state_nxt = S_PAR_B;
            end
            S_PAR_B: begin
                tx_req  = 1'b1;
                tx_byte = parity_q ? CH_1 : CH_0;
                if (acc) state_nxt = S_PAR_NL;
            end
            S_PAR_NL: begin
                tx_req  = 1'b1;
                tx_byte = CH_NL;
                if (acc) state_nxt = S_DONE;
            end
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            line_q   <= '0;
            bit_q    <= 1'b0;
            just_acc <= 1'b0;
`ifdef UART_MEM_DUMP_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            just_acc <= acc;
            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        addr_q <= cmd_addr;
                        rem_q  <= cmd_len;
                        line_q <= '0;
`ifdef UART_MEM_DUMP_PARITY_EN
                        parity_q <= 1'b0;
`endif
                    end
                end
                S_WAIT: begin
                    bit_q <= mem_rd_data;
`ifdef UART_MEM_DUMP_PARITY_EN
                    parity_q <= parity_q ^ mem_rd_data;
`endif
                end
                S_SEND: begin
                    if (acc) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_dec;
                        line_q <= line_inc;
                    end
                end
                S_EOL: begin
                    if (acc) line_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed self-checking bench for uart_mem_dump (ADDR_W=16, LINE_BITS=64).
// Expected parity suffix follows UART_MEM_DUMP_PARITY_EN.
module tb_uart_mem_dump;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        tx_wait = 1'b0;
    logic        mem_rd_data = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_we;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic        busy;
    logic        done;
    logic        err;

    uart_mem_dump #(.ADDR_W(16), .LINE_BITS(64)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_we       (tx_we),
        .tx_wait     (tx_wait),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    bit          mem [0:65535];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  rxq [$];
    logic [7:0]  exq [$];
    logic [15:0] rdlog [$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic        hold_chk = 1'b0;
    logic        hold_prev = 1'b0;
    logic [7:0]  hold_data = '0;
    logic        pend = 1'b0;
    logic [15:0] pend_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitors sample mid-cycle; an accepted byte is one with tx_we=1, tx_wait=0 here.
    always @(negedge clk) begin
        if (tx_we && !tx_wait) rxq.push_back(tx_data);
        if (mem_rd_en) rdlog.push_back(mem_rd_addr);
        if (done) done_cnt++;
        if (err) err_cnt++;
        pend      = mem_rd_en;
        pend_addr = mem_rd_addr;
        if (hold_chk && hold_prev) begin
            chk("hold_we", {31'd0, tx_we}, 32'd1);
            chk("hold_data", {24'd0, tx_data}, {24'd0, hold_data});
        end
        hold_prev = tx_we && tx_wait;
        hold_data = tx_data;
    end

    // Read data valid during the cycle after mem_rd_en, zero otherwise.
    always @(posedge clk) begin
        #1 mem_rd_data = pend ? mem[pend_addr] : 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_cmd(input logic [15:0] a, input logic [15:0] n);
        send_byte(8'h44);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    task automatic wait_done(input string tag, input int d0, input int unsigned budget);
        int unsigned k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (2) @(posedge clk);
        chk(tag, done_cnt - d0, 32'd1);
    endtask

    task automatic wait_bytes(input string tag, input int n, input int unsigned budget);
        int unsigned k = 0;
        while (rxq.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk(tag, {31'd0, rxq.size() >= n}, 32'd1);
    endtask

    task automatic build_exp(input int unsigned a, input int unsigned n);
        int unsigned lc = 0;
        bit par = 1'b0;
        bit b;
        exq.delete();
        for (int unsigned i = 0; i < n; i++) begin
            b = mem[(a + i) % 65536];
            exq.push_back(b ? 8'h31 : 8'h30);
            par ^= b;
            lc++;
            if (lc == 64) begin
                exq.push_back(8'h0A);
                lc = 0;
            end
        end
        if (lc != 0) exq.push_back(8'h0A);
`ifdef UART_MEM_DUMP_PARITY_EN
        exq.push_back(8'h50);
        exq.push_back(par ? 8'h31 : 8'h30);
        exq.push_back(8'h0A);
`endif
    endtask

    task automatic check_out(input string tag);
        int idx = 0;
        chk({tag, "_count"}, rxq.size(), exq.size());
        if (rxq.size() != 0 && exq.size() != 0) begin
            for (int i = 0; i < rxq.size() && i < exq.size(); i++) begin
                if (rxq[i] !== exq[i]) begin
                    idx = i;
                    break;
                end
            end
            chk({tag, "_data"}, {24'd0, rxq[idx]}, {24'd0, exq[idx]});
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        chk({tag, "_tx_we"}, {31'd0, tx_we}, 32'd0);
        chk({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        chk({tag, "_rd_addr"}, {16'd0, mem_rd_addr}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        logic [9:0] pat;

        mem[0] = 1'b1; mem[1] = 1'b0; mem[2] = 1'b1; mem[3] = 1'b1;
        for (int i = 0; i < 128; i++) mem[16'h0100 + i] = ((i * 7) ^ (i >> 2)) & 1;
        mem[16'hFFFE] = 1'b1;
        mem[16'hFFFF] = 1'b0;
        pat = 10'b1100110101;
        for (int i = 0; i < 10; i++) mem[16'h0200 + i] = pat[9 - i];

        repeat (3) @(posedge clk);
        #1 check_reset_vals("rst");
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        // Basic 4-bit dump: "1011\n"
        rxq.delete();
        build_exp(0, 4);
        d0 = done_cnt;
        send_cmd(16'h0000, 16'd4);
        chk("t1_busy_high", {31'd0, busy}, 32'd1);
        wait_done("t1_done", d0, 2000);
        check_out("t1");
        chk("t1_busy_low", {31'd0, busy}, 32'd0);

        // Two full lines; a byte during the dump is ignored without err
        rxq.delete();
        build_exp(16'h0100, 128);
        e0 = err_cnt;
        d0 = done_cnt;
        send_cmd(16'h0100, 16'd128);
        send_byte(8'h41);
        wait_done("t2_done", d0, 5000);
        chk("t2_len130", rxq.size(), 32'd130);
        check_out("t2");
        chk("t2_no_err", err_cnt - e0, 32'd0);

        // Address wrap
        rxq.delete();
        rdlog.delete();
        build_exp(16'hFFFE, 3);
        d0 = done_cnt;
        send_cmd(16'hFFFE, 16'd3);
        wait_done("t3_done", d0, 2000);
        chk("t3_nreads", rdlog.size(), 32'd3);
        if (rdlog.size() >= 3) begin
            chk("t3_rd0", {16'd0, rdlog[0]}, 32'h0000FFFE);
            chk("t3_rd1", {16'd0, rdlog[1]}, 32'h0000FFFF);
            chk("t3_rd2", {16'd0, rdlog[2]}, 32'h00000000);
        end
        check_out("t3");

        // Invalid command byte in IDLE
        rxq.delete();
        e0 = err_cnt;
        send_byte(8'h41);
        repeat (3) @(posedge clk);
        chk("t4_err_pulse", err_cnt - e0, 32'd1);
        chk("t4_no_tx", rxq.size(), 32'd0);
        build_exp(0, 4);
        d0 = done_cnt;
        send_cmd(16'h0000, 16'd4);
        wait_done("t4_done", d0, 2000);
        check_out("t4");

        // Back-pressure: tx_wait held 50 cycles mid-dump
        rxq.delete();
        build_exp(16'h0200, 10);
        d0 = done_cnt;
        send_cmd(16'h0200, 16'd10);
        wait_bytes("t5_started", 3, 500);
        @(posedge clk); #1 tx_wait = 1'b1; hold_chk = 1'b1;
        repeat (50) @(posedge clk);
        #1 chk("t5_we_held", {31'd0, tx_we}, 32'd1);
        tx_wait = 1'b0; hold_chk = 1'b0;
        wait_done("t5_done", d0, 2000);
        check_out("t5");

        // Asynchronous reset mid-dump, then a clean dump
        rxq.delete();
        send_cmd(16'h0100, 16'd100);
        wait_bytes("t6_started", 5, 1000);
        @(posedge clk); #1 resetn = 1'b0;
        #1 check_reset_vals("t6_rst");
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
        rxq.delete();
        build_exp(0, 4);
        d0 = done_cnt;
        send_cmd(16'h0000, 16'd4);
        wait_done("t6_done", d0, 2000);
        check_out("t6");

        // Zero-length dump
        rxq.delete();
        build_exp(16'h0010, 0);
        d0 = done_cnt;
        send_cmd(16'h0010, 16'd0);
        wait_done("t7_done", d0, 500);
        check_out("t7");
        chk("t7_busy_low", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
